// File: rtl/ide_dma_handshake.sv
// ----------------------------------------------------------------------------
// ide_dma_handshake
//
// Device-side multiword DMA handshake sequencer for the IDE interface. Paces
// one DMA transfer of a programmed word count: raises DMARQ, waits for the
// host to grant DMACK, counts DIOR/DIOW strobes, tells the datapath FIFO when
// each word moves, and drops DMARQ ahead of the last word or when the FIFO
// cannot keep up. Pin outputs feed negedge-registered tristate primitives.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start              one-cycle pulse: latch count/dir, begin transfer
//   dir                1 = device-to-host (DIOR), 0 = host-to-device (DIOW)
//   count              words to transfer (0 legal)
//   abort              terminate the current transfer early
//   word_ready         datapath can source/sink the next word
//   dmack_n            host DMACK, active low, synchronized
//   dior_n, diow_n     host strobes, active low, synchronized
//   dmarq_out          value for the DMARQ pin
//   dmarq_oe           DMARQ pin output enable (= busy)
//   data_oe            DD bus drive enable, device-to-host only
//   xfer               one-cycle pulse per completed word strobe
//   busy               transfer in progress
//   done               one-cycle pulse at transfer end
//   aborted            sticky: last transfer ended by abort
//   remaining          words not yet strobed
// ----------------------------------------------------------------------------
module ide_dma_handshake #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   dir,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic                   abort,
    input  logic                   word_ready,
    input  logic                   dmack_n,
    input  logic                   dior_n,
    input  logic                   diow_n,
    output logic                   dmarq_out,
    output logic                   dmarq_oe,
    output logic                   data_oe,
    output logic                   xfer,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [COUNT_WIDTH-1:0] remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_XFER,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                 r_state;
    logic                   r_dir;
    logic                   r_busy;
    logic                   r_dmarq;
    logic                   r_data_oe;
    logic                   r_xfer;
    logic                   r_done;
    logic                   r_aborted;
    logic [COUNT_WIDTH-1:0] r_remaining;

    // Strobe/DMACK event stage: edges are detected on the raw synchronized
    // pins and registered, so the FSM always acts one clock after the edge
    // that sampled the pin event. Strobe and DMACK-release seen together
    // therefore reach the FSM together.
    logic                   r_stb_q;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_dmack_q;

    logic                   w_stb_n;
    logic                   w_count_word;
    logic [COUNT_WIDTH-1:0] w_rem_next;

    assign w_stb_n      = r_dir ? dior_n : diow_n;

    // A strobe only counts while words are outstanding; extra host strobes
    // at zero are swallowed so the counter never wraps.
    assign w_count_word = r_rise && (r_remaining != '0);
    assign w_rem_next   = w_count_word ? (r_remaining - COUNT_WIDTH'(1)) : r_remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dir       <= 1'b0;
            r_busy      <= 1'b0;
            r_dmarq     <= 1'b0;
            r_data_oe   <= 1'b0;
            r_xfer      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_remaining <= '0;
            // Strobe and DMACK idle high, so reset them high to avoid a
            // phantom edge on the first clock after reset.
            r_stb_q     <= 1'b1;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_dmack_q   <= 1'b1;
        end else begin
            // NOTE: every state register here uses <= so all updates see the
            // pre-edge values; a blocking assignment would let later
            // statements read half-updated state and break the pipelining.
            r_stb_q   <= w_stb_n;
            r_rise    <= w_stb_n & ~r_stb_q & ~dmack_n;
            r_fall    <= ~w_stb_n & r_stb_q & ~dmack_n;
            r_dmack_q <= dmack_n;
            r_data_oe <= r_dir & r_busy & ~dmack_n & ~dior_n;

            r_xfer    <= 1'b0;
            r_done    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // start has priority over abort; abort is ignored here.
                    if (start) begin
                        r_dir       <= dir;
                        r_remaining <= count;
                        r_aborted   <= 1'b0;
                        r_busy      <= 1'b1;
                        if (count == '0) begin
                            r_state <= S_FINISH;
                        end else if (word_ready) begin
                            r_state <= S_REQ;
                            r_dmarq <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_FINISH;
                    end else if (word_ready) begin
                        r_dmarq <= 1'b1;
                        r_state <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_dmarq   <= 1'b0;
                        // Host already holding DMACK must be allowed to
                        // finish its burst before the transfer closes.
                        r_state   <= r_dmack_q ? S_FINISH : S_DRAIN;
                    end else if (!r_dmack_q) begin
                        r_state <= S_XFER;
                    end
                end

                S_XFER: begin
                    if (w_count_word) begin
                        r_xfer      <= 1'b1;
                        r_remaining <= w_rem_next;
                    end
                    // DMARQ low inside XFER is the stop flag: dropping it
                    // during the falling strobe tells the host this is the
                    // last word of the burst.
                    if (r_fall && ((r_remaining == COUNT_WIDTH'(1)) || !word_ready)) begin
                        r_dmarq <= 1'b0;
                    end
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_dmarq   <= 1'b0;
                        r_state   <= S_DRAIN;
                    end else if (r_dmack_q) begin
                        // Exit decision uses the post-count value so a word
                        // strobed on the release cycle is not lost.
                        if (w_rem_next == '0) begin
                            r_dmarq <= 1'b0;
                            r_state <= S_FINISH;
                        end else if (word_ready) begin
                            r_dmarq <= 1'b1;
                            r_state <= S_REQ;
                        end else begin
                            r_dmarq <= 1'b0;
                            r_state <= S_WAIT;
                        end
                    end
                end

                S_DRAIN: begin
                    if (w_count_word) begin
                        r_xfer      <= 1'b1;
                        r_remaining <= w_rem_next;
                    end
                    if (r_dmack_q) begin
                        r_state <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_dmarq <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dmarq_out = r_dmarq;
    assign dmarq_oe  = r_busy;
    assign data_oe   = r_data_oe;
    assign xfer      = r_xfer;
    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;
    assign remaining = r_remaining;

endmodule
